fsm_ctrl: RTL and testbench
===========================

FSM_CTRL -- requirements
Module: fsm_ctrl

Interface
REQ-001 Parameter: N, 5, number of FIFOs supervised (main, VC0, VC1, D0, D1).
REQ-002 Parameter: W, 5, threshold width per FIFO.
REQ-003 Port: clk  input  1  single clock; all state changes on posedge.
REQ-004 Port: reset  input  1  asynchronous, active-low reset; 0 = in reset.
REQ-005 Port: init  input  1  request to (re)enter configuration.
REQ-006 Port: th_low_in  input  N*W  packed low thresholds {D1,D0,Vc1,Vc0,main}, main in [W-1:0].
REQ-007 Port: th_high_in  input  N*W  packed high thresholds, same packing.
REQ-008 Port: empties  input  N  per-FIFO empty flags, same bit order.
REQ-009 Port: errors  input  N  per-FIFO error flags, same bit order.
REQ-010 Port: state  output  5  one-hot state {ERROR,ACTIVE,IDLE,INIT,RESET}, RESET = bit 0.
REQ-011 Port: th_low_out  output  N*W  latched low thresholds to FIFOs.
REQ-012 Port: th_high_out  output  N*W  latched high thresholds to FIFOs.
REQ-013 Port: idle_out  output  1  high while state is IDLE.
REQ-014 Port: error_out  output  N  sticky per-FIFO error record.
REQ-015 Port: cfg_bad  output  1  threshold check failed in INIT.

Function
REQ-016 The state register SHALL be one-hot, and every output SHALL be registered or a pure decode of registers.
REQ-017 RESET->INIT on the first posedge with reset=1.
REQ-018 In INIT, th_low_out/th_high_out SHALL load th_low_in/th_high_in every cycle; outside INIT they hold.
REQ-019 INIT->IDLE when init=0 (subject to REQ-030); INIT holds while init=1.
REQ-020 IDLE->ACTIVE when &empties=0; ACTIVE->IDLE when &empties=1.
REQ-021 IDLE or ACTIVE -> INIT when init=1 and errors=0.
REQ-022 IDLE, ACTIVE or INIT -> ERROR when |errors=1; priority errors > init > empties.
REQ-023 On that transition edge, error_out SHALL OR in errors, and it SHALL keep OR-ing in errors every cycle while in ERROR.
REQ-024 ERROR SHALL be left only via reset; init and empties are ignored there.
REQ-025 Decisions use input values sampled at the posedge; one transition per cycle; outputs update in the same cycle as the state (latency 1 from input).
REQ-026 idle_out = state[2]; no glitching beyond register decode.

Reset
REQ-027 reset=0 SHALL, asynchronously and at any time (including mid-ACTIVE or ERROR), force state=5'b00001, th_low_out=0, th_high_out=0, error_out=0, cfg_bad=0, idle_out=0.
REQ-028 Deassertion takes effect at the next posedge; no input is sampled while reset=0.

Configuration
REQ-029 Macro FSM_THRESH_CHECK_EN selects threshold validation.
REQ-030 Defined: INIT->IDLE additionally requires low<=high (unsigned) for every FIFO; otherwise stay in INIT with cfg_bad=1, cleared on the cycle all pairs pass.
REQ-031 Undefined: no check; cfg_bad tied 0; REQ-019 is unconditional.

Verification
REQ-032 reset=0 then 1, init=0, th_low_in={D,C,A,B,3}, th_high_in={A,9,7,8,6} (hex per field) -> RESET, INIT, IDLE on successive edges; th_*_out equal the inputs.
REQ-033 In IDLE, empties 1F->1E -> ACTIVE next edge, idle_out=0; empties back to 1F -> IDLE.
REQ-034 In ACTIVE, errors=5'b00001 for one cycle then 0 -> ERROR, error_out=00001 held; init=1 and empties toggles give no exit.
REQ-035 In ERROR, reset pulsed low between edges -> state=00001 and all outputs 0 immediately, without waiting for a clock edge.
REQ-036 In IDLE, init=1 and errors=00010 in the same cycle -> ERROR, not INIT.
REQ-037 With FSM_THRESH_CHECK_EN, main low=7, high=6 -> stays INIT with cfg_bad=1; high changed to 8 -> IDLE, cfg_bad=0; without the macro -> IDLE directly.

Source files
------------

// File: rtl/fsm_ctrl.sv
// fsm_ctrl: one-hot supervisor FSM latching FIFO thresholds and recording sticky FIFO errors.
// Define FSM_THRESH_CHECK_EN to require low<=high for every FIFO before INIT may exit.
module fsm_ctrl #(
   parameter int N = 5,
   parameter int W = 5
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           init,
   input  logic [N*W-1:0] th_low_in,
   input  logic [N*W-1:0] th_high_in,
   input  logic [N-1:0]   empties,
   input  logic [N-1:0]   errors,
   output logic [4:0]     state,
   output logic [N*W-1:0] th_low_out,
   output logic [N*W-1:0] th_high_out,
   output logic           idle_out,
   output logic [N-1:0]   error_out,
   output logic           cfg_bad
);
   typedef enum logic [4:0] {
      S_RESET  = 5'b00001,
      S_INIT   = 5'b00010,
      S_IDLE   = 5'b00100,
      S_ACTIVE = 5'b01000,
      S_ERROR  = 5'b10000
   } state_t;

   state_t         st_q, st_d;
   logic [N*W-1:0] lo_q, lo_d, hi_q, hi_d;
   logic [N-1:0]   err_q, err_d;
   logic           bad_q, bad_d, pass;

`ifdef FSM_THRESH_CHECK_EN
   logic [N-1:0] ok;
   for (genvar i = 0; i < N; i++) begin : g_chk
      assign ok[i] = th_low_in[i*W +: W] <= th_high_in[i*W +: W];
   end
   assign pass = &ok;
`else
   assign pass = 1'b1;
`endif

   always_comb begin
      st_d  = st_q;
      lo_d  = lo_q;
      hi_d  = hi_q;
      err_d = err_q;
      bad_d = bad_q;
      case (st_q)
         S_RESET: st_d = S_INIT;
         S_INIT: begin
            lo_d = th_low_in;
            hi_d = th_high_in;
            if (|errors) begin
               st_d  = S_ERROR;
               err_d = err_q | errors;
            end else begin
               bad_d = ~pass;
               if (!init && pass) st_d = S_IDLE;
            end
         end
         S_IDLE, S_ACTIVE: begin
            if (|errors) begin
               st_d  = S_ERROR;
               err_d = err_q | errors;
            end else if (init) begin
               st_d = S_INIT;
            end else begin
               st_d = &empties ? S_IDLE : S_ACTIVE;
            end
         end
         S_ERROR: err_d = err_q | errors;
         default: st_d = S_RESET;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         st_q  <= S_RESET;
         lo_q  <= '0;
         hi_q  <= '0;
         err_q <= '0;
         bad_q <= 1'b0;
      end else begin
         st_q  <= st_d;
         lo_q  <= lo_d;
         hi_q  <= hi_d;
         err_q <= err_d;
         bad_q <= bad_d;
      end
   end

   assign state       = st_q;
   assign th_low_out  = lo_q;
   assign th_high_out = hi_q;
   assign idle_out    = st_q[2];
   assign error_out   = err_q;
   assign cfg_bad     = bad_q;
endmodule

// File: tb/tb_fsm_ctrl.sv
// tb_fsm_ctrl: directed scenarios plus randomized run against a rule-based reference model.
module tb_fsm_ctrl;
   localparam int N = 5;
   localparam int W = 5;
   localparam int RS = 0, IN = 1, ID = 2, AC = 3, ER = 4;

   logic clk = 1'b0, reset = 1'b1, init = 1'b0;
   logic [N*W-1:0] thl = '0, thh = '0;
   logic [N-1:0] emp = 5'h1f, errs = '0;
   logic [4:0] state;
   logic [N*W-1:0] tlo, thi;
   logic idle_out, cfg_bad;
   logic [N-1:0] eout;

   int tests = 0, fails = 0;
   int m_st;
   logic [N*W-1:0] m_lo, m_hi;
   logic [N-1:0] m_err;
   logic m_bad;

   fsm_ctrl #(.N(N), .W(W)) dut (
      .clk(clk), .reset(reset), .init(init),
      .th_low_in(thl), .th_high_in(thh),
      .empties(emp), .errors(errs),
      .state(state), .th_low_out(tlo), .th_high_out(thi),
      .idle_out(idle_out), .error_out(eout), .cfg_bad(cfg_bad)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   function automatic bit thr_ok();
`ifdef FSM_THRESH_CHECK_EN
      for (int i = 0; i < N; i++)
         if (((thl >> (W*i)) & 31) > ((thh >> (W*i)) & 31)) return 1'b0;
`endif
      return 1'b1;
   endfunction

   task automatic m_reset();
      m_st = RS; m_lo = '0; m_hi = '0; m_err = '0; m_bad = 1'b0;
   endtask

   // Priority-ordered rules: ERROR absorbs, then errors, then init, then empties.
   task automatic m_step();
      if (!reset) begin m_reset(); return; end
      if (m_st == ER) m_err |= errs;
      else if (m_st == RS) m_st = IN;
      else if (errs != 0) begin
         if (m_st == IN) begin m_lo = thl; m_hi = thh; end
         m_err |= errs; m_st = ER;
      end else if (m_st == IN) begin
         m_lo = thl; m_hi = thh; m_bad = !thr_ok();
         if (!init && thr_ok()) m_st = ID;
      end else if (init) m_st = IN;
      else m_st = (emp == 5'h1f) ? ID : AC;
   endtask

   function automatic logic [61:0] dut_v();
      return {state, tlo, thi, idle_out, eout, cfg_bad};
   endfunction

   function automatic logic [61:0] mod_v();
      logic [4:0] s;
      s = 5'(1 << m_st);
      return {s, m_lo, m_hi, (m_st == ID), m_err, m_bad};
   endfunction

   task automatic cyc();
      @(posedge clk);
      m_step();
      #1;
   endtask

   task automatic boot(input logic [N*W-1:0] lo, input logic [N*W-1:0] hi);
      reset = 1'b0; init = 1'b0; errs = '0; emp = 5'h1f; thl = lo; thh = hi;
      #1; m_reset();
      reset = 1'b1;
      cyc(); cyc();
   endtask

   task automatic test_reset();
      #1 reset = 1'b0;
      #1 m_reset();
      tests++;
      if (dut_v() !== {5'b00001, 57'b0})
         $display("FAIL reset_state: got %h want %h", dut_v(), {5'b00001, 57'b0});
      if (dut_v() !== {5'b00001, 57'b0}) fails++;
      reset = 1'b1;
   endtask

   task automatic test_boot();
      reset = 1'b0;
      thl = {5'hD, 5'hC, 5'hA, 5'hB, 5'h3};
      thh = {5'hA, 5'h9, 5'h7, 5'h8, 5'h6};
      #1 m_reset();
      reset = 1'b1;
      cyc();
      tests++;
      if (state !== 5'b00010 || tlo !== '0) begin
         fails++; $display("FAIL boot_init: got %b/%h want 00010/0", state, tlo);
      end
      cyc();
      tests++;
`ifdef FSM_THRESH_CHECK_EN
      if (state !== 5'b00010 || cfg_bad !== 1'b1) begin
         fails++; $display("FAIL boot_chk: got %b/%b want 00010/1", state, cfg_bad);
      end
`else
      if (state !== 5'b00100 || tlo !== {5'hD, 5'hC, 5'hA, 5'hB, 5'h3} ||
          thi !== {5'hA, 5'h9, 5'h7, 5'h8, 5'h6}) begin
         fails++; $display("FAIL boot_idle: got %b/%h/%h want 00100/thresholds", state, tlo, thi);
      end
`endif
      tests++;
      if (dut_v() !== mod_v()) begin
         fails++; $display("FAIL boot_model: got %h want %h", dut_v(), mod_v());
      end
   endtask

   task automatic test_active();
      boot('0, '1);
      emp = 5'h1e; cyc();
      tests++;
      if (state !== 5'b01000 || idle_out !== 1'b0) begin
         fails++; $display("FAIL to_active: got %b/%b want 01000/0", state, idle_out);
      end
      emp = 5'h1f; cyc();
      tests++;
      if (state !== 5'b00100 || idle_out !== 1'b1) begin
         fails++; $display("FAIL to_idle: got %b/%b want 00100/1", state, idle_out);
      end
   endtask

   task automatic test_error();
      boot('0, '1);
      emp = 5'h1e; cyc();
      errs = 5'b00001; cyc();
      tests++;
      if (state !== 5'b10000 || eout !== 5'b00001) begin
         fails++; $display("FAIL to_error: got %b/%b want 10000/00001", state, eout);
      end
      errs = '0; init = 1'b1;
      for (int k = 0; k < 4; k++) begin
         emp = emp ^ 5'h01; cyc();
         tests++;
         if (state !== 5'b10000 || eout !== 5'b00001) begin
            fails++; $display("FAIL error_hold: got %b/%b want 10000/00001", state, eout);
         end
      end
      init = 1'b0;
   endtask

   task automatic test_async_reset();
      @(negedge clk);
      #2 reset = 1'b0;
      #1 m_reset();
      tests++;
      if (dut_v() !== {5'b00001, 57'b0}) begin
         fails++; $display("FAIL async_reset: got %h want %h", dut_v(), {5'b00001, 57'b0});
      end
      reset = 1'b1;
   endtask

   task automatic test_priority();
      boot('0, '1);
      init = 1'b1; errs = 5'b00010; cyc();
      tests++;
      if (state !== 5'b10000 || eout !== 5'b00010) begin
         fails++; $display("FAIL err_over_init: got %b/%b want 10000/00010", state, eout);
      end
      init = 1'b0; errs = '0;
   endtask

   task automatic test_reenter();
      boot('0, '1);
      emp = 5'h1e; cyc();
      init = 1'b1; thl = 25'h0012345; thh = 25'h1ffffff; cyc();
      tests++;
      if (state !== 5'b00010) begin
         fails++; $display("FAIL reenter: got %b want 00010", state);
      end
      cyc();
      tests++;
      if (tlo !== 25'h0012345 || thi !== 25'h1ffffff) begin
         fails++; $display("FAIL reload: got %h/%h want 0012345/1ffffff", tlo, thi);
      end
      init = 1'b0;
   endtask

   task automatic test_thresh();
      boot({20'b0, 5'd7}, {20'b0, 5'd6});
      tests++;
`ifdef FSM_THRESH_CHECK_EN
      if (state !== 5'b00010 || cfg_bad !== 1'b1) begin
         fails++; $display("FAIL thr_bad: got %b/%b want 00010/1", state, cfg_bad);
      end
      thh = {20'b0, 5'd8}; cyc();
      tests++;
      if (state !== 5'b00100 || cfg_bad !== 1'b0) begin
         fails++; $display("FAIL thr_fixed: got %b/%b want 00100/0", state, cfg_bad);
      end
`else
      if (state !== 5'b00100 || cfg_bad !== 1'b0) begin
         fails++; $display("FAIL thr_nochk: got %b/%b want 00100/0", state, cfg_bad);
      end
`endif
   endtask

   task automatic test_random();
      boot('0, '1);
      for (int k = 0; k < 3000; k++) begin
         errs = ($urandom_range(0, 40) == 0) ? 5'($urandom) : 5'b0;
         init = ($urandom_range(0, 9) == 0);
         emp  = ($urandom_range(0, 2) == 0) ? 5'($urandom) : 5'h1f;
         if ($urandom_range(0, 3) == 0) begin
            thl = 25'($urandom); thh = 25'($urandom);
         end
         if ($urandom_range(0, 40) == 0) begin
            reset = 1'b0;
            #1 m_reset();
            tests++;
            if (dut_v() !== mod_v()) begin
               fails++; $display("FAIL rand_areset: got %h want %h", dut_v(), mod_v());
            end
            reset = 1'b1;
         end
         cyc();
         tests++;
         if (dut_v() !== mod_v()) begin
            fails++; $display("FAIL rand_cycle %0d: got %h want %h", k, dut_v(), mod_v());
         end
      end
   endtask

   initial begin
      test_reset();
      test_boot();
      test_active();
      test_error();
      test_async_reset();
      test_priority();
      test_reenter();
      test_thresh();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
